// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the single-port byte RAM: port 0 = instruction fetch, port 1 = load/store.
// Optional macro RAM_ARB_RR_EN selects round-robin tie breaking; otherwise port 1 wins ties.
module ram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              I_clk,
    input  logic              I_reset_n,
    input  logic              I_req0,
    input  logic              I_write0,
    input  logic [1:0]        I_size0,
    input  logic [ADDR_W-1:0] I_addr0,
    input  logic [DATA_W-1:0] I_wdata0,
    input  logic              I_req1,
    input  logic              I_write1,
    input  logic [1:0]        I_size1,
    input  logic [ADDR_W-1:0] I_addr1,
    input  logic [DATA_W-1:0] I_wdata1,
    output logic              O_rdy0,
    output logic              O_rdy1,
    output logic              O_rsp0,
    output logic              O_rsp1,
    output logic [DATA_W-1:0] O_rdata0,
    output logic [DATA_W-1:0] O_rdata1,
    output logic              O_busy,
    output logic              O_ram_enable,
    output logic              O_ram_write,
    output logic [1:0]        O_ram_size,
    output logic [ADDR_W-1:0] O_ram_addr,
    output logic [DATA_W-1:0] O_ram_wdata,
    input  logic [DATA_W-1:0] I_ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              owner;
    logic              win0;
    logic              win1;
    logic              accept;
    logic              grant;
    logic              cmd_write;
    logic [1:0]        cmd_size;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

`ifdef RAM_ARB_RR_EN
    logic rr_ptr;

    // Pointer holds the last granted port; a tie goes to the other one.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (I_req0 && I_req1) begin
            win1 = ~rr_ptr;
            win0 = rr_ptr;
        end else begin
            win0 = I_req0;
            win1 = I_req1;
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= grant;
        end
    end
`else
    always_comb begin
        win1 = I_req1;
        win0 = I_req0 & ~I_req1;
    end
`endif

    assign O_rdy0 = (state == S_IDLE) & win0;
    assign O_rdy1 = (state == S_IDLE) & win1;
    assign accept = (O_rdy0 & I_req0) | (O_rdy1 & I_req1);
    assign grant  = O_rdy1;
    assign O_busy = (state != S_IDLE);

    always_comb begin
        cmd_write = I_write0;
        cmd_size  = I_size0;
        cmd_addr  = I_addr0;
        cmd_wdata = I_wdata0;
        if (grant) begin
            cmd_write = I_write1;
            cmd_size  = I_size1;
            cmd_addr  = I_addr1;
            cmd_wdata = I_wdata1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command registers: loaded on accept, enable drops after the single ISSUE cycle.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            O_ram_enable <= 1'b0;
            O_ram_write  <= 1'b0;
            O_ram_size   <= 2'd0;
            O_ram_addr   <= '0;
            O_ram_wdata  <= '0;
            owner        <= 1'b0;
        end else if (accept) begin
            O_ram_enable <= 1'b1;
            O_ram_write  <= cmd_write;
            O_ram_size   <= cmd_size;
            O_ram_addr   <= cmd_addr;
            O_ram_wdata  <= cmd_wdata;
            owner        <= grant;
        end else if (state == S_ISSUE) begin
            O_ram_enable <= 1'b0;
        end
    end

    // Response: one-cycle pulse to the owner; read data captured only for reads.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            O_rsp0   <= 1'b0;
            O_rsp1   <= 1'b0;
            O_rdata0 <= '0;
            O_rdata1 <= '0;
        end else begin
            O_rsp0 <= (state == S_WAIT) & ~owner;
            O_rsp1 <= (state == S_WAIT) & owner;
            if (state == S_WAIT && !O_ram_write) begin
                if (owner) begin
                    O_rdata1 <= I_ram_rdata;
                end else begin
                    O_rdata0 <= I_ram_rdata;
                end
            end
        end
    end

    a_rsp_onehot: assert property (@(posedge I_clk) disable iff (!I_reset_n) !(O_rsp0 && O_rsp1));
    a_rdy_idle:   assert property (@(posedge I_clk) disable iff (!I_reset_n) (O_rdy0 || O_rdy1) |-> (state == S_IDLE));
    a_rdy_onehot: assert property (@(posedge I_clk) disable iff (!I_reset_n) !(O_rdy0 && O_rdy1));

endmodule
